// File: rtl/cmd_seq_checker_pkg.sv
// ---------------------------------------------------------------------------
// cmd_seq_pkg
// Shared types and constants for the MazeRunner command sequencer/checker.
//   state_t     : sequencer states
//   fail_code_t : failure classification reported on first_fail_code_o
//   CMD_W       : command word width
//   POS_ACK     : positive-acknowledge byte returned by the robot
//   CAL/HDNG/MOVE/SOLVE : opcodes carried in the top nibble of a command
// No ports.
// ---------------------------------------------------------------------------
package cmd_seq_pkg;

  localparam int         CMD_W   = 16;
  localparam logic [7:0] POS_ACK = 8'hA5;

  localparam logic [3:0] CAL   = 4'h0;
  localparam logic [3:0] HDNG  = 4'h2;
  localparam logic [3:0] MOVE  = 4'h4;
  localparam logic [3:0] SOLVE = 4'h6;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_SENT,
    WAIT_RESP,
    NEXT,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    FC_NONE     = 2'b00,
    FC_BAD_RESP = 2'b01,
    FC_TIMEOUT  = 2'b10
  } fail_code_t;

  // Opcode of a MazeRunner command word.
  function automatic logic [3:0] cmdOpcode(input logic [CMD_W-1:0] c);
    return c[CMD_W-1 -: 4];
  endfunction

endpackage

// File: rtl/cmd_seq_checker_slot_mem.sv
// ---------------------------------------------------------------------------
// cmd_slot_mem
// DEPTH x (CMD_W+TMO_W) register array holding {command, timeout} per slot.
// One synchronous write port, one combinational read port. Not reset.
//   clk_i    : clock
//   we_i     : write enable
//   waddr_i  : write slot index
//   wdata_i  : {command, timeout} to store
//   raddr_i  : read slot index
//   rdata_o  : {command, timeout} of slot raddr_i
// ---------------------------------------------------------------------------
module cmd_slot_mem
  import cmd_seq_pkg::*;
#(
  parameter  int DEPTH = 8,
  parameter  int TMO_W = 24,
  localparam int AW    = $clog2(DEPTH),
  localparam int WIDTH = CMD_W + TMO_W
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Slot contents survive reset so a loaded script can be rerun after a reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cmd_seq_checker.sv
// ---------------------------------------------------------------------------
// cmd_seq_checker
// Issues up to DEPTH stored commands in order to a RemoteComm-style sender,
// checks each response byte against EXP_RESP and applies a per-command
// timeout (0 = never expire). Reports pass/fail counts and the first failure.
//
// Ports:
//   clk_i, rst_ni           : clock, asynchronous active-low reset
//   wr_en_i/wr_idx_i/wr_cmd_i/wr_tmo_i : slot load (only while IDLE or DONE)
//   num_cmds_i, stop_on_fail_i, start_i : run control, sampled on start
//   send_cmd_o, cmd_o, cmd_sent_i       : sender handshake
//   resp_rdy_i, resp_i                  : response byte strobe
//   busy_o, done_o, pass_cnt_o, fail_cnt_o,
//   first_fail_idx_o, first_fail_code_o : run status
//
// Build option RESP_LOG_EN: adds rd_idx_i/rd_resp_o and a per-slot log of
// the received response byte (00 for a timed-out slot), cleared on start.
// ---------------------------------------------------------------------------
module cmd_seq_checker
  import cmd_seq_pkg::*;
#(
  parameter  int         DEPTH    = 8,
  parameter  int         TMO_W    = 24,
  parameter  logic [7:0] EXP_RESP = POS_ACK,
  localparam int         AW       = $clog2(DEPTH),
  localparam int         CW       = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_idx_i,
  input  logic [CMD_W-1:0] wr_cmd_i,
  input  logic [TMO_W-1:0] wr_tmo_i,
  input  logic [CW-1:0]    num_cmds_i,
  input  logic             start_i,
  input  logic             stop_on_fail_i,
  output logic             send_cmd_o,
  output logic [CMD_W-1:0] cmd_o,
  input  logic             cmd_sent_i,
  input  logic             resp_rdy_i,
  input  logic [7:0]       resp_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CW-1:0]    pass_cnt_o,
  output logic [CW-1:0]    fail_cnt_o,
  output logic [AW-1:0]    first_fail_idx_o,
  output logic [1:0]       first_fail_code_o
`ifdef RESP_LOG_EN
  ,
  input  logic [AW-1:0]    rd_idx_i,
  output logic [7:0]       rd_resp_o
`endif
);

  state_t             state_q;
  logic [AW-1:0]      idx_q;
  logic [AW-1:0]      lastIdx_q;
  logic               stopOnFail_q;
  logic               failSeen_q;
  logic [TMO_W-1:0]   tmoCnt_q;
  logic [CMD_W-1:0]   cmd_q;
  logic               sendCmd_q;
  logic               busy_q;
  logic               done_q;
  logic [CW-1:0]      passCnt_q;
  logic [CW-1:0]      failCnt_q;
  logic [AW-1:0]      firstFailIdx_q;
  fail_code_t         firstFailCode_q;

  logic [AW-1:0]            rdAddr;
  logic [CMD_W+TMO_W-1:0]   slotRd;
  logic [CMD_W-1:0]         slotCmd;
  logic [TMO_W-1:0]         slotTmo;
  logic                     idleLike;
  logic                     startOk;
  logic [CW-1:0]            numEff;
  logic                     tmoLast;
  logic                     evDone;
  logic                     evFail;
  fail_code_t               evCode;
  logic [7:0]               evByte;

  assign idleLike = (state_q == IDLE) || (state_q == DONE);
  assign startOk  = start_i && idleLike;
  assign numEff   = (num_cmds_i > CW'(DEPTH)) ? CW'(DEPTH) : num_cmds_i;
  assign tmoLast  = (tmoCnt_q == TMO_W'(1));

  // The slot is read on the edge that enters ISSUE, so the address must
  // already point at the slot about to be issued: 0 on start, idx+1 from NEXT.
  assign rdAddr  = (state_q == NEXT) ? idx_q + 1'b1 : '0;
  assign slotCmd = slotRd[CMD_W+TMO_W-1 -: CMD_W];
  assign slotTmo = slotRd[TMO_W-1:0];

  cmd_slot_mem #(
    .DEPTH (DEPTH),
    .TMO_W (TMO_W)
  ) u_slot_mem (
    .clk_i   (clk_i),
    .we_i    (wr_en_i && idleLike),
    .waddr_i (wr_idx_i),
    .wdata_i ({wr_cmd_i, wr_tmo_i}),
    .raddr_i (rdAddr),
    .rdata_o (slotRd)
  );

  // Outcome of the current command this cycle. A response beats a timeout
  // expiring on the same cycle; early responses during WAIT_SENT are dropped,
  // but the timeout already runs there so a sender that never acks is caught.
  always_comb begin
    evDone = 1'b0;
    evFail = 1'b0;
    evCode = FC_NONE;
    evByte = '0;
    if ((state_q == WAIT_RESP) && resp_rdy_i) begin
      evDone = 1'b1;
      evFail = (resp_i != EXP_RESP);
      evCode = evFail ? FC_BAD_RESP : FC_NONE;
      evByte = resp_i;
    end else if (((state_q == WAIT_RESP) || (state_q == WAIT_SENT)) && tmoLast) begin
      evDone = 1'b1;
      evFail = 1'b1;
      evCode = FC_TIMEOUT;
    end
  end

  // Sequencer with all outputs registered. The ISSUE outputs (send_cmd, cmd,
  // timeout load) are set on the edge that enters ISSUE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= IDLE;
      idx_q           <= '0;
      lastIdx_q       <= '0;
      stopOnFail_q    <= 1'b0;
      failSeen_q      <= 1'b0;
      tmoCnt_q        <= '0;
      cmd_q           <= '0;
      sendCmd_q       <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      passCnt_q       <= '0;
      failCnt_q       <= '0;
      firstFailIdx_q  <= '0;
      firstFailCode_q <= FC_NONE;
    end else begin
      sendCmd_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            passCnt_q       <= '0;
            failCnt_q       <= '0;
            firstFailIdx_q  <= '0;
            firstFailCode_q <= FC_NONE;
            failSeen_q      <= 1'b0;
            idx_q           <= '0;
            stopOnFail_q    <= stop_on_fail_i;
            lastIdx_q       <= AW'(numEff - 1'b1);
            if (numEff == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= ISSUE;
              done_q    <= 1'b0;
              busy_q    <= 1'b1;
              sendCmd_q <= 1'b1;
              cmd_q     <= slotCmd;
              tmoCnt_q  <= slotTmo;
            end
          end
        end
        ISSUE: begin
          state_q <= WAIT_SENT;
        end
        WAIT_SENT, WAIT_RESP: begin
          // A zero count means the timeout is disabled, so it never wraps.
          if (tmoCnt_q != '0) begin
            tmoCnt_q <= tmoCnt_q - 1'b1;
          end
          if (evDone) begin
            state_q    <= NEXT;
            failSeen_q <= evFail;
            if (evFail) begin
              failCnt_q <= failCnt_q + 1'b1;
              if (failCnt_q == '0) begin
                firstFailIdx_q  <= idx_q;
                firstFailCode_q <= evCode;
              end
            end else begin
              passCnt_q <= passCnt_q + 1'b1;
            end
          end else if ((state_q == WAIT_SENT) && cmd_sent_i) begin
            state_q <= WAIT_RESP;
          end
        end
        NEXT: begin
          if ((failSeen_q && stopOnFail_q) || (idx_q == lastIdx_q)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            idx_q     <= idx_q + 1'b1;
            state_q   <= ISSUE;
            sendCmd_q <= 1'b1;
            cmd_q     <= slotCmd;
            tmoCnt_q  <= slotTmo;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign send_cmd_o        = sendCmd_q;
  assign cmd_o             = cmd_q;
  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign pass_cnt_o        = passCnt_q;
  assign fail_cnt_o        = failCnt_q;
  assign first_fail_idx_o  = firstFailIdx_q;
  assign first_fail_code_o = firstFailCode_q;

`ifdef RESP_LOG_EN
  logic [7:0] respLog_q [DEPTH];

  // Response log: the byte received for each slot of the current run,
  // 00 where the slot timed out or was not reached.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        respLog_q[i] <= '0;
      end
    end else if (startOk) begin
      for (int i = 0; i < DEPTH; i++) begin
        respLog_q[i] <= '0;
      end
    end else if (evDone) begin
      respLog_q[idx_q] <= evByte;
    end
  end

  assign rd_resp_o = respLog_q[rd_idx_i];
`endif

endmodule

// File: tb/tb_cmd_seq_checker.sv
// ---------------------------------------------------------------------------
// tb_cmd_seq_checker
// Self-checking bench for cmd_seq_checker. A sender model acknowledges and
// responds after per-slot delays; the expected outcome of every run (issue
// cycles, done cycle, counters, first failure, response log) is computed
// from those delays with plain arithmetic before the run starts.
// ---------------------------------------------------------------------------
module tb_cmd_seq_checker;

  localparam int DEPTH  = 8;
  localparam int TMO_W  = 24;
  localparam int AW     = 3;
  localparam int CW     = 4;
  localparam int BUDGET = 3000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wr_en;
  logic [AW-1:0]    wr_idx;
  logic [15:0]      wr_cmd;
  logic [TMO_W-1:0] wr_tmo;
  logic [CW-1:0]    num_cmds;
  logic             start;
  logic             stop_on_fail;
  logic             send_cmd;
  logic [15:0]      cmd;
  logic             cmd_sent;
  logic             resp_rdy;
  logic [7:0]       resp;
  logic             busy;
  logic             done;
  logic [CW-1:0]    pass_cnt;
  logic [CW-1:0]    fail_cnt;
  logic [AW-1:0]    ff_idx;
  logic [1:0]       ff_code;
`ifdef RESP_LOG_EN
  logic [AW-1:0]    rd_idx;
  logic [7:0]       rd_resp;
`endif

  int checks = 0;
  int fails  = 0;

  // Per-slot script: command, timeout, and the sender's behaviour for it
  // (cycles after issue for ack, response, optional early stray response).
  logic [15:0] sCmd  [DEPTH];
  int          sTmo  [DEPTH];
  int          sAck  [DEPTH];
  int          sRsp  [DEPTH];
  int          sEarly[DEPTH];
  logic [7:0]  sByte [DEPTH];
  logic [15:0] baseCmd [4] = '{16'h0000, 16'h23FF, 16'h2000, 16'h4002};

  always #5 clk = ~clk;

  cmd_seq_checker #(
    .DEPTH    (DEPTH),
    .TMO_W    (TMO_W),
    .EXP_RESP (8'hA5)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .wr_en_i           (wr_en),
    .wr_idx_i          (wr_idx),
    .wr_cmd_i          (wr_cmd),
    .wr_tmo_i          (wr_tmo),
    .num_cmds_i        (num_cmds),
    .start_i           (start),
    .stop_on_fail_i    (stop_on_fail),
    .send_cmd_o        (send_cmd),
    .cmd_o             (cmd),
    .cmd_sent_i        (cmd_sent),
    .resp_rdy_i        (resp_rdy),
    .resp_i            (resp),
    .busy_o            (busy),
    .done_o            (done),
    .pass_cnt_o        (pass_cnt),
    .fail_cnt_o        (fail_cnt),
    .first_fail_idx_o  (ff_idx),
    .first_fail_code_o (ff_code)
`ifdef RESP_LOG_EN
    ,
    .rd_idx_i          (rd_idx),
    .rd_resp_o         (rd_resp)
`endif
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      fails++;
      $display("[TB] FAIL %s: observed 'h%0h, expected 'h%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Test-plan baseline: ack after 10, A5 after 20, timeout 1000.
  task automatic setDefaults();
    for (int i = 0; i < DEPTH; i++) begin
      sCmd[i]   = (i < 4) ? baseCmd[i] : 16'(16'h6000 + i);
      sTmo[i]   = 1000;
      sAck[i]   = 10;
      sRsp[i]   = 20;
      sEarly[i] = 0;
      sByte[i]  = 8'hA5;
    end
  endtask

  task automatic loadSlots();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      wr_en  = 1'b1;
      wr_idx = AW'(i);
      wr_cmd = sCmd[i];
      wr_tmo = TMO_W'(sTmo[i]);
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Runs one sequence and checks it. noise adds ignored writes/starts while
  // busy; abortCyc (non-zero) pulls reset on that cycle and checks outputs.
  task automatic applyStimulus(input int num, input bit sof, input bit noise, input int abortCyc);
    int n, t, dur, code;
    int expPass, expFail, expFfIdx, expFfCode, expDone, expCnt;
    int expIssue [DEPTH];
    int expLog   [DEPTH];
    int issueK, curK, t0;
    bit pending, doneSeen, aborted;

    // Reference outcome of the run.
    n = (num > DEPTH) ? DEPTH : num;
    expPass = 0; expFail = 0; expFfIdx = 0; expFfCode = 0; expCnt = 0;
    for (int k = 0; k < DEPTH; k++) begin
      expIssue[k] = 0;
      expLog[k]   = 0;
    end
    t = 1;
    expDone = 1;
    for (int k = 0; k < n; k++) begin
      expIssue[k] = t;
      expCnt++;
      if (sTmo[k] != 0 && (sTmo[k] <= sAck[k] || sRsp[k] > sTmo[k])) begin
        code = 2;
        dur  = sTmo[k];
      end else begin
        dur       = sRsp[k];
        code      = (sByte[k] == 8'hA5) ? 0 : 1;
        expLog[k] = int'(sByte[k]);
      end
      if (code == 0) begin
        expPass++;
      end else begin
        if (expFail == 0) begin
          expFfIdx  = k;
          expFfCode = code;
        end
        expFail++;
      end
      t = t + dur + 2;
      expDone = t;
      if (code != 0 && sof) break;
    end

    @(negedge clk);
    num_cmds     = CW'(num);
    stop_on_fail = sof;
    start        = 1'b1;
    issueK = 0; curK = 0; t0 = 0;
    pending = 1'b0; doneSeen = 1'b0; aborted = 1'b0;

    for (int c = 1; c <= BUDGET && !doneSeen; c++) begin
      @(negedge clk);
      start = 1'b0;
      wr_en = 1'b0;
      if (abortCyc != 0 && c == abortCyc) begin
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_done", int'(done), 0);
        checkOutput("abort_send_cmd", int'(send_cmd), 0);
        checkOutput("abort_cmd", int'(cmd), 0);
        checkOutput("abort_pass_cnt", int'(pass_cnt), 0);
        checkOutput("abort_fail_cnt", int'(fail_cnt), 0);
        checkOutput("abort_ff_idx", int'(ff_idx), 0);
        checkOutput("abort_ff_code", int'(ff_code), 0);
        aborted = 1'b1;
        break;
      end
      if (send_cmd) begin
        if (issueK < expCnt) begin
          checkOutput("issue_cycle", c, expIssue[issueK]);
          checkOutput("issue_cmd", int'(cmd), int'(sCmd[issueK]));
          checkOutput("busy_at_issue", int'(busy), 1);
        end else begin
          checkOutput("issue_count", issueK + 1, expCnt);
        end
        t0      = c;
        curK    = (issueK < DEPTH) ? issueK : DEPTH - 1;
        pending = 1'b1;
        issueK++;
      end
      if (done) begin
        doneSeen = 1'b1;
        checkOutput("done_cycle", c, expDone);
      end
      cmd_sent = pending && (c == t0 + sAck[curK]);
      resp_rdy = pending && ((c == t0 + sRsp[curK]) || (sEarly[curK] != 0 && c == t0 + sEarly[curK]));
      resp     = (c == t0 + sRsp[curK]) ? sByte[curK] : 8'($urandom);
      if (noise && !doneSeen) begin
        if ($urandom_range(3) == 0) begin
          wr_en  = 1'b1;
          wr_idx = AW'($urandom);
          wr_cmd = 16'($urandom);
          wr_tmo = TMO_W'($urandom);
        end
        start = ($urandom_range(7) == 0);
      end
    end

    cmd_sent = 1'b0;
    resp_rdy = 1'b0;
    wr_en    = 1'b0;
    start    = 1'b0;

    if (aborted) begin
      @(negedge clk);
      rst_n = 1'b1;
      return;
    end

    if (!doneSeen) checkOutput("done_timeout", 0, 1);
    checkOutput("issue_total", issueK, expCnt);
    checkOutput("pass_cnt", int'(pass_cnt), expPass);
    checkOutput("fail_cnt", int'(fail_cnt), expFail);
    checkOutput("ff_idx", int'(ff_idx), expFfIdx);
    checkOutput("ff_code", int'(ff_code), expFfCode);
    checkOutput("busy_at_done", int'(busy), 0);
    checkOutput("done_level", int'(done), 1);
`ifdef RESP_LOG_EN
    for (int k = 0; k < DEPTH; k++) begin
      rd_idx = AW'(k);
      #1;
      checkOutput("resp_log", int'(rd_resp), expLog[k]);
    end
`endif
  endtask

  initial begin
    rst_n        = 1'b0;
    wr_en        = 1'b0;
    wr_idx       = '0;
    wr_cmd       = '0;
    wr_tmo       = '0;
    num_cmds     = '0;
    start        = 1'b0;
    stop_on_fail = 1'b0;
    cmd_sent     = 1'b0;
    resp_rdy     = 1'b0;
    resp         = '0;
`ifdef RESP_LOG_EN
    rd_idx       = '0;
`endif
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_send_cmd", int'(send_cmd), 0);
    checkOutput("rst_cmd", int'(cmd), 0);
    checkOutput("rst_pass_cnt", int'(pass_cnt), 0);
    checkOutput("rst_fail_cnt", int'(fail_cnt), 0);
    checkOutput("rst_ff_idx", int'(ff_idx), 0);
    checkOutput("rst_ff_code", int'(ff_code), 0);
    rst_n = 1'b1;

    $display("[TB] all four commands acknowledged");
    setDefaults();
    loadSlots();
    applyStimulus(4, 1'b0, 1'b0, 0);

    $display("[TB] bad response on slot 1, run-all then stop-on-fail");
    sByte[1] = 8'h5A;
    loadSlots();
    applyStimulus(4, 1'b0, 1'b0, 0);
    applyStimulus(4, 1'b1, 1'b0, 0);

    $display("[TB] slot 2 times out, stray byte during slot 3 WAIT_SENT");
    setDefaults();
    sTmo[2]   = 50;
    sRsp[2]   = 80;
    sAck[3]   = 40;
    sRsp[3]   = 50;
    sEarly[3] = 28;
    loadSlots();
    applyStimulus(4, 1'b0, 1'b0, 0);

    $display("[TB] response on the expiry cycle");
    setDefaults();
    sTmo[1]  = 20;
    sTmo[2]  = 20;
    sByte[2] = 8'h5A;
    loadSlots();
    applyStimulus(4, 1'b0, 1'b0, 0);

    $display("[TB] reset during slot 1 WAIT_RESP, then rerun");
    setDefaults();
    loadSlots();
    applyStimulus(4, 1'b0, 1'b0, 38);
    applyStimulus(4, 1'b0, 1'b0, 0);

    $display("[TB] zero-length run and clamped run");
    applyStimulus(0, 1'b0, 1'b0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      sAck[i] = 2;
      sRsp[i] = 5;
    end
    loadSlots();
    applyStimulus(15, 1'b0, 1'b0, 0);

    $display("[TB] randomized runs");
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        sCmd[i]   = 16'($urandom);
        sAck[i]   = int'($urandom_range(6, 1));
        sRsp[i]   = sAck[i] + int'($urandom_range(8, 1));
        sTmo[i]   = ($urandom_range(3) == 0) ? 0 : int'($urandom_range(14, 1));
        sEarly[i] = ($urandom_range(1) == 0) ? 0 : int'($urandom_range(sAck[i], 1));
        sByte[i]  = ($urandom_range(3) == 0) ? 8'($urandom) : 8'hA5;
      end
      loadSlots();
      applyStimulus(int'($urandom_range(15)), 1'($urandom_range(1)), 1'b1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/cmd_seq_checker.md
Name: cmd_seq_checker

Overview:
Parametrised, synthesizable command sequencer/checker for MazeRunner bring-up. It holds a queue of DEPTH 16-bit commands, each with its own timeout. It issues them in order to a RemoteComm-style sender and checks each response byte against an expected value. It replaces hand-written per-command fork/timeout sequences and can run on-FPGA next to RemoteComm.

Parameters:
DEPTH, 8, number of command slots (power of 2, 2..64)
TMO_W, 24, width of the per-command timeout counter in clk cycles
EXP_RESP, 8'hA5, expected positive-acknowledge byte

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write one slot while IDLE or DONE; ignored otherwise
wr_idx  in  $clog2(DEPTH)  slot index to write
wr_cmd  in  16  command word for the slot
wr_tmo  in  TMO_W  timeout in cycles for the slot; 0 means no timeout
num_cmds  in  $clog2(DEPTH)+1  count of slots to run (1..DEPTH); sampled on start
start  in  1  one-cycle pulse that begins a run from slot 0
stop_on_fail  in  1  1 = halt at first failure, 0 = run all; sampled on start
send_cmd  out  1  one-cycle pulse to the sender
cmd  out  16  command presented to the sender; held until cmd_sent
cmd_sent  in  1  the sender has finished transmitting
resp_rdy  in  1  response byte valid (one-cycle pulse)
resp  in  8  response byte
busy  out  1  a run is in progress
done  out  1  run complete; held until the next start
pass_cnt  out  $clog2(DEPTH)+1  commands that passed
fail_cnt  out  $clog2(DEPTH)+1  commands that failed
first_fail_idx  out  $clog2(DEPTH)  slot of the first failure
first_fail_code  out  2  00 none, 01 bad resp, 10 timeout

Behaviour:
- Reset values: every output is 0, cmd is 16'h0000, first_fail_code is 00, and the state is IDLE. Slot memory is not reset.
- IDLE:
  - start moves to ISSUE. On the same edge: counters clear, first_fail_* clear, done clears, idx is set to 0, and num_cmds and stop_on_fail are latched.
  - num_cmds of 0 means DONE on the next cycle with all counters at 0.
  - num_cmds greater than DEPTH is clamped to DEPTH.
- ISSUE:
  - cmd comes from slot[idx] and is registered. send_cmd is 1 for exactly this cycle.
  - The timeout counter loads wr_tmo of the slot. Next state is WAIT_SENT.
- WAIT_SENT:
  - On cmd_sent, go to WAIT_RESP.
  - The timeout counter decrements every cycle in both WAIT_SENT and WAIT_RESP.
- WAIT_RESP:
  - resp_rdy with resp == EXP_RESP is a pass: pass_cnt increments.
  - resp_rdy with any other value is a fail with code 01.
  - A timeout is a fail with code 10: the counter reaches 1→0 with no resp_rdy on that cycle.
  - If resp_rdy and expiry occur on the same cycle, resp_rdy wins.
  - On fail: fail_cnt increments, and first_fail_idx/first_fail_code are written only when fail_cnt was 0.
  - Any outcome goes to NEXT.
- NEXT:
  - If a fail occurred and stop_on_fail=1, go to DONE.
  - Otherwise, if idx == num_cmds-1, go to DONE.
  - Otherwise increment idx and go to ISSUE. This adds 1 cycle of inter-command gap.
- DONE:
  - done=1 and busy=0.
  - start begins a new run, exactly as from IDLE.
- busy is 1 in ISSUE, WAIT_SENT, WAIT_RESP and NEXT.
- resp_rdy outside WAIT_RESP is ignored. A resp_rdy in WAIT_SENT (early) is not captured.
- start while busy is ignored. wr_en while busy is ignored.
- Asynchronous reset mid-run returns to IDLE with all outputs at reset values. An in-flight command is abandoned.
- A zero timeout (wr_tmo = 0) disables expiry for that slot.
- Counters never wrap, because pass_cnt + fail_cnt ≤ num_cmds.

Optional Feature:
RESP_LOG_EN.
- Defined: adds input rd_idx [$clog2(DEPTH)] and output rd_resp [8].
  - Each received resp byte is logged into resp_log[idx], including bad responses.
  - A timed-out slot logs 8'h00.
  - rd_resp is a combinational read of resp_log[rd_idx].
  - The log is cleared to 0 on start.
- Undefined: the ports and the storage are absent, and all other behaviour is identical.

Decomposition:
- Package cmd_seq_pkg holds:
  - enum state_t {IDLE, ISSUE, WAIT_SENT, WAIT_RESP, NEXT, DONE}
  - enum fail_code_t {FC_NONE=2'b00, FC_BAD_RESP=2'b01, FC_TIMEOUT=2'b10}
  - localparam POS_ACK=8'hA5
  - MazeRunner opcode constants: CAL=4'h0, HDNG=4'h2, MOVE=4'h4, SOLVE=4'h6
- Sub-module cmd_slot_mem: a DEPTH×(16+TMO_W) register array with one write port and one read port.

Test Plan:
1. Load slots 0..3 = {16'h0000, 16'h23FF, 16'h2000, 16'h4002} with tmo=1000. The sender model acks after 10 cycles and responds 8'hA5 after 20 cycles. num_cmds=4 → done=1, pass_cnt=4, fail_cnt=0, first_fail_code=00.
2. Same load, but slot 1 responds 8'h5A. stop_on_fail=0 → pass_cnt=3, fail_cnt=1, first_fail_idx=1, first_fail_code=01. stop_on_fail=1 → done after slot 1 with pass_cnt=1.
3. Slot 2 has tmo=50 and its response comes at cycle 80 → fail code 10 at idx 2. The late resp_rdy is ignored, and the next command is issued 1 cycle after NEXT.
4. resp_rdy on the exact expiry cycle with 8'hA5 → counted as a pass.
5. Assert rst_n=0 during WAIT_RESP of slot 1 → all outputs 0 immediately. Then start → the run restarts from slot 0.
6. With RESP_LOG_EN: run case 2 and read rd_idx=0..3 → A5, 5A, A5, A5. Case 3 reads 00 at idx 2.
